vram_multibank: RTL and testbench

Parametrised video-RAM subsystem for the EpochTV1 video path. It replaces the fixed pair of 4K×8 single-port VRAMs with NBANK banks of configurable depth and width. Each bank keeps its own VDC-side strobe port. A shared host port (loader, save-state, debugger) gives access to any bank. Host accesses are arbitrated into cycles where the VDC leaves that bank idle, so the VDC never sees a wait state.

---
 rtl/vram_multibank_if.sv | 25 ++
 rtl/vram_multibank.sv | 83 ++++++++
 tb/tb_vram_multibank.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/vram_multibank_if.sv
// vram_multibank_if: VDC strobe ports plus shared host port for the multibank VRAM.
interface vram_multibank_if #(
  parameter int NBANK  = 2,
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 8
);
  logic                    CE;
  logic [NBANK*AWIDTH-1:0] VA;
  logic [NBANK*DWIDTH-1:0] VD_O;
  logic [NBANK*DWIDTH-1:0] VD_I;
  logic [NBANK-1:0]        nVRD;
  logic [NBANK-1:0]        nVWR;
  logic                    H_REQ;
  logic                    H_WE;
  logic [1:0]              H_BANK;
  logic [AWIDTH-1:0]       H_A;
  logic [DWIDTH-1:0]       H_DI;
  logic [DWIDTH-1:0]       H_DO;
  logic                    H_ACK;
  logic [7:0]              H_STALL;
  modport master (output CE, VA, VD_O, nVRD, nVWR, H_REQ, H_WE, H_BANK, H_A, H_DI,
                  input VD_I, H_DO, H_ACK, H_STALL);
  modport slave (input CE, VA, VD_O, nVRD, nVWR, H_REQ, H_WE, H_BANK, H_A, H_DI,
                 output VD_I, H_DO, H_ACK, H_STALL);
endinterface

// File: rtl/vram_multibank.sv
// vram_multibank: NBANK single-port VRAM banks; the host port borrows cycles the VDC leaves idle.
module vram_multibank #(
  parameter int NBANK  = 2,
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 8
) (
  input logic              CLK,
  input logic              RESB,
  vram_multibank_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t              st;
  logic                h_we;
  logic [1:0]          h_bank;
  logic [AWIDTH-1:0]   h_a;
  logic [DWIDTH-1:0]   h_di;
  logic [DWIDTH-1:0]   h_do;
  logic                h_ack;
  logic [7:0]          h_stall;
  logic [3:0]          busy;
  logic [DWIDTH-1:0]   hq [4];
  logic [NBANK*DWIDTH-1:0] vd_i;
  // Absent banks look permanently idle and read as zero, so an out-of-range host request acks at once.
  for (genvar k = 0; k < 4; k++) begin : g_bank
    if (k < NBANK) begin : g_on
      logic [DWIDTH-1:0] mem [2**AWIDTH];
      logic [DWIDTH-1:0] vq;
      logic [AWIDTH-1:0] va;
      logic              vwr;
      logic              vrd;
      logic              hwr;
      assign va       = bus.VA[k*AWIDTH +: AWIDTH];
      assign vwr      = bus.CE & ~bus.nVWR[k];
      assign vrd      = bus.CE & ~bus.nVRD[k] & bus.nVWR[k];
      assign busy[k]  = bus.CE & ~(bus.nVRD[k] & bus.nVWR[k]);
      assign hwr      = st == WAIT && h_bank == 2'(k) && !busy[k] && h_we;
      assign hq[k]    = mem[h_a];
      assign vd_i[k*DWIDTH +: DWIDTH] = vq;
      always_ff @(posedge CLK)
        if (vwr) mem[va] <= bus.VD_O[k*DWIDTH +: DWIDTH];
        else if (hwr) mem[h_a] <= h_di;
      always_ff @(posedge CLK or negedge RESB)
        if (!RESB) vq <= '0;
        else if (vrd) vq <= mem[va];
    end else begin : g_off
      assign busy[k] = 1'b0;
      assign hq[k]   = '0;
    end
  end
  always_ff @(posedge CLK or negedge RESB)
    if (!RESB) begin
      st      <= IDLE;
      h_we    <= 1'b0;
      h_bank  <= '0;
      h_a     <= '0;
      h_di    <= '0;
      h_do    <= '0;
      h_ack   <= 1'b0;
      h_stall <= '0;
    end else begin
      h_ack <= 1'b0;
      case (st)
        IDLE: if (bus.H_REQ) begin
          st      <= WAIT;
          h_we    <= bus.H_WE;
          h_bank  <= bus.H_BANK;
          h_a     <= bus.H_A;
          h_di    <= bus.H_DI;
          h_stall <= '0;
        end
        WAIT: if (!busy[h_bank]) begin
          st    <= ACK;
          h_ack <= 1'b1;
          h_do  <= h_we ? h_do : hq[h_bank];
        end else h_stall <= h_stall + 8'(h_stall != 8'hFF);
        default: st <= IDLE;
      endcase
    end
  assign bus.VD_I    = vd_i;
  assign bus.H_DO    = h_do;
  assign bus.H_ACK   = h_ack;
  assign bus.H_STALL = h_stall;
endmodule

// File: tb/tb_vram_multibank.sv
// tb_vram_multibank: directed checks of VDC strobes, host arbitration, stall counter and a 4-bank build.
module tb_vram_multibank;
  logic CLK = 1'b0;
  logic RESB = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 CLK = ~CLK;
  vram_multibank_if b ();
  vram_multibank_if #(.NBANK(4), .AWIDTH(10), .DWIDTH(16)) b4 ();
  vram_multibank u_a (.CLK(CLK), .RESB(RESB), .bus(b));
  vram_multibank #(.NBANK(4), .AWIDTH(10), .DWIDTH(16)) u_b (.CLK(CLK), .RESB(RESB), .bus(b4));

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic host_txn(input logic we, input logic [1:0] bank, input logic [11:0] a,
                          input logic [7:0] di, output int cyc);
    b.H_REQ = 1'b1; b.H_WE = we; b.H_BANK = bank; b.H_A = a; b.H_DI = di;
    cyc = 0;
    do begin tick(); cyc++; end while (b.H_ACK !== 1'b1 && cyc < 50);
    b.H_REQ = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    n_chk++; if (b.VD_I !== 16'h0) begin n_fail++; $display("FAIL reset_vd_i: got %h want 0000", b.VD_I); end
    n_chk++; if (b.H_DO !== 8'h0) begin n_fail++; $display("FAIL reset_h_do: got %h want 00", b.H_DO); end
    n_chk++; if (b.H_ACK !== 1'b0) begin n_fail++; $display("FAIL reset_h_ack: got %b want 0", b.H_ACK); end
    n_chk++; if (b.H_STALL !== 8'h0) begin n_fail++; $display("FAIL reset_h_stall: got %h want 00", b.H_STALL); end
    n_chk++; if (b4.VD_I !== 64'h0) begin n_fail++; $display("FAIL reset_vd_i4: got %h want 0", b4.VD_I); end
  endtask

  task automatic test_vdc_roundtrip;
    b.CE = 1'b1; b.VA = {12'h123, 12'h123}; b.VD_O = {8'h3C, 8'hA5}; b.nVWR = 2'b00;
    tick();
    b.nVWR = 2'b11; b.nVRD = 2'b00;
    tick();
    n_chk++; if (b.VD_I !== 16'h3CA5) begin n_fail++; $display("FAIL vdc_roundtrip: got %h want 3ca5", b.VD_I); end
    b.nVRD = 2'b11;
    tick();
    n_chk++; if (b.VD_I !== 16'h3CA5) begin n_fail++; $display("FAIL vdc_hold: got %h want 3ca5", b.VD_I); end
  endtask

  task automatic test_host_uncontended;
    int cyc;
    host_txn(1'b1, 2'd1, 12'hFFF, 8'h77, cyc);
    n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL host_wr_latency: got %0d want 2", cyc); end
    n_chk++; if (b.H_STALL !== 8'h0) begin n_fail++; $display("FAIL host_wr_stall: got %h want 00", b.H_STALL); end
    n_chk++; if (b.H_ACK !== 1'b0) begin n_fail++; $display("FAIL ack_pulse_width: got %b want 0", b.H_ACK); end
    host_txn(1'b0, 2'd1, 12'hFFF, 8'h00, cyc);
    n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL host_rd_latency: got %0d want 2", cyc); end
    n_chk++; if (b.H_DO !== 8'h77) begin n_fail++; $display("FAIL host_rd_data: got %h want 77", b.H_DO); end
    n_chk++; if (b.H_STALL !== 8'h0) begin n_fail++; $display("FAIL host_rd_stall: got %h want 00", b.H_STALL); end
  endtask

  task automatic test_contention;
    int cyc;
    logic seen;
    b.CE = 1'b1; b.VA = {12'h000, 12'h123}; b.nVRD = 2'b10;
    b.H_REQ = 1'b1; b.H_WE = 1'b0; b.H_BANK = 2'd0; b.H_A = 12'h123;
    tick();
    seen = 1'b0;
    repeat (10) begin tick(); if (b.H_ACK === 1'b1) seen = 1'b1; end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL contend_no_ack: got %b want 0", seen); end
    n_chk++; if (b.H_STALL !== 8'd10) begin n_fail++; $display("FAIL contend_stall: got %0d want 10", b.H_STALL); end
    b.nVRD = 2'b11;
    tick();
    n_chk++; if (b.H_ACK !== 1'b1) begin n_fail++; $display("FAIL contend_ack_after_release: got %b want 1", b.H_ACK); end
    n_chk++; if (b.H_DO !== 8'hA5) begin n_fail++; $display("FAIL contend_rd_data: got %h want a5", b.H_DO); end
    b.H_REQ = 1'b0;
    tick();
    b.nVRD = 2'b10;
    host_txn(1'b1, 2'd1, 12'h010, 8'h5A, cyc);
    n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL parallel_bank_latency: got %0d want 2", cyc); end
    b.nVRD = 2'b11;
    host_txn(1'b0, 2'd1, 12'h010, 8'h00, cyc);
    n_chk++; if (b.H_DO !== 8'h5A) begin n_fail++; $display("FAIL parallel_bank_data: got %h want 5a", b.H_DO); end
  endtask

  task automatic test_boundaries;
    int cyc;
    b.VA = {12'h123, 12'h123}; b.nVRD = 2'b10;
    tick();
    b.VA = {12'h123, 12'h200}; b.VD_O = {8'h00, 8'h11}; b.nVWR = 2'b10;
    tick();
    n_chk++; if (b.VD_I[7:0] !== 8'hA5) begin n_fail++; $display("FAIL both_strobes_hold: got %h want a5", b.VD_I[7:0]); end
    b.nVWR = 2'b11;
    tick();
    n_chk++; if (b.VD_I[7:0] !== 8'h11) begin n_fail++; $display("FAIL both_strobes_write: got %h want 11", b.VD_I[7:0]); end
    b.nVRD = 2'b11;
    host_txn(1'b1, 2'd3, 12'h123, 8'hEE, cyc);
    n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL bad_bank_wr_latency: got %0d want 2", cyc); end
    n_chk++; if (b.H_DO !== 8'h5A) begin n_fail++; $display("FAIL bad_bank_wr_h_do: got %h want 5a", b.H_DO); end
    host_txn(1'b0, 2'd3, 12'h123, 8'h00, cyc);
    n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL bad_bank_rd_latency: got %0d want 2", cyc); end
    n_chk++; if (b.H_DO !== 8'h00) begin n_fail++; $display("FAIL bad_bank_rd_data: got %h want 00", b.H_DO); end
    b.VA = {12'h123, 12'h123}; b.nVRD = 2'b00;
    tick();
    b.nVRD = 2'b11;
    n_chk++; if (b.VD_I !== 16'h3CA5) begin n_fail++; $display("FAIL bad_bank_untouched: got %h want 3ca5", b.VD_I); end
  endtask

  task automatic test_stall_saturation_reset;
    int cyc;
    logic seen;
    b.CE = 1'b1; b.VA = {12'hFFF, 12'h000}; b.nVRD = 2'b01;
    b.H_REQ = 1'b1; b.H_WE = 1'b0; b.H_BANK = 2'd1; b.H_A = 12'hFFF;
    tick();
    seen = 1'b0;
    repeat (300) begin tick(); if (b.H_ACK === 1'b1) seen = 1'b1; end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL sat_no_ack: got %b want 0", seen); end
    n_chk++; if (b.H_STALL !== 8'd255) begin n_fail++; $display("FAIL sat_stall: got %0d want 255", b.H_STALL); end
    RESB = 1'b0;
    #1;
    n_chk++; if (b.H_ACK !== 1'b0) begin n_fail++; $display("FAIL midreset_ack: got %b want 0", b.H_ACK); end
    n_chk++; if (b.H_STALL !== 8'h0) begin n_fail++; $display("FAIL midreset_stall: got %h want 00", b.H_STALL); end
    n_chk++; if (b.VD_I !== 16'h0) begin n_fail++; $display("FAIL midreset_vd_i: got %h want 0000", b.VD_I); end
    b.H_REQ = 1'b0; b.nVRD = 2'b11;
    tick();
    RESB = 1'b1;
    seen = 1'b0;
    repeat (5) begin tick(); if (b.H_ACK === 1'b1) seen = 1'b1; end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL postreset_no_ack: got %b want 0", seen); end
    host_txn(1'b0, 2'd1, 12'hFFF, 8'h00, cyc);
    n_chk++; if (b.H_DO !== 8'h77) begin n_fail++; $display("FAIL postreset_mem_kept: got %h want 77", b.H_DO); end
  endtask

  task automatic test_ce_gate;
    int cyc;
    b.CE = 1'b0; b.VA = {12'h123, 12'h123}; b.VD_O = 16'hFFFF; b.nVRD = 2'b00; b.nVWR = 2'b00;
    host_txn(1'b0, 2'd0, 12'h123, 8'h00, cyc);
    n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL ce_off_latency: got %0d want 2", cyc); end
    n_chk++; if (b.H_DO !== 8'hA5) begin n_fail++; $display("FAIL ce_off_data: got %h want a5", b.H_DO); end
    b.nVRD = 2'b11; b.nVWR = 2'b11; b.CE = 1'b1;
  endtask

  task automatic test_param_sweep;
    int cyc;
    b4.CE = 1'b1; b4.VA = {10'h3FF, 30'h0}; b4.VD_O = {16'hBEEF, 48'h0}; b4.nVWR = 4'b0111;
    tick();
    b4.nVWR = 4'b1111;
    b4.H_REQ = 1'b1; b4.H_WE = 1'b0; b4.H_BANK = 2'd3; b4.H_A = 10'h3FF;
    cyc = 0;
    do begin tick(); cyc++; end while (b4.H_ACK !== 1'b1 && cyc < 50);
    b4.H_REQ = 1'b0;
    n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL sweep_latency: got %0d want 2", cyc); end
    n_chk++; if (b4.H_DO !== 16'hBEEF) begin n_fail++; $display("FAIL sweep_host_data: got %h want beef", b4.H_DO); end
    tick();
    b4.nVRD = 4'b0111;
    tick();
    b4.nVRD = 4'b1111;
    n_chk++; if (b4.VD_I[63:48] !== 16'hBEEF) begin n_fail++; $display("FAIL sweep_vdc_data: got %h want beef", b4.VD_I[63:48]); end
  endtask

  initial begin
    b.CE = 1'b0; b.VA = '0; b.VD_O = '0; b.nVRD = '1; b.nVWR = '1;
    b.H_REQ = 1'b0; b.H_WE = 1'b0; b.H_BANK = '0; b.H_A = '0; b.H_DI = '0;
    b4.CE = 1'b0; b4.VA = '0; b4.VD_O = '0; b4.nVRD = '1; b4.nVWR = '1;
    b4.H_REQ = 1'b0; b4.H_WE = 1'b0; b4.H_BANK = '0; b4.H_A = '0; b4.H_DI = '0;
    repeat (2) tick();
    test_reset();
    RESB = 1'b1;
    tick();
    test_vdc_roundtrip();
    test_host_uncontended();
    test_contention();
    test_boundaries();
    test_stall_saturation_reset();
    test_ce_gate();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
